// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Responder end of the CPU external bus strobe/ready protocol. A rising edge
//   on i_bus_clk that hits the address window starts an access. The access is
//   completed after WAIT_STATES wait cycles, then held in DONE with
//   o_bus_data_ready=1 until the CPU drops the strobe (4-phase handshake).
//   Outputs are forced to 0 whenever no read data is being presented, so
//   several instances can be ORed onto the CPU inputs.
//
//   Optional feature macro: BUS_RESP_ACCESS_CNT_EN
//     defined   : index NUM_REGS-1 is a read-only access counter (+1 per access).
//     undefined : index NUM_REGS-1 is an ordinary scratch register.
//
// Ports
//   i_clk            in   system clock, rising edge
//   i_rst            in   asynchronous reset, active low
//   i_bus_clk        in   CPU bus strobe
//   i_bus_we         in   1 = write, 0 = read
//   i_bus_addr       in   access address
//   i_bus_data       in   write data
//   o_bus_data       out  read data (0 when not presenting read data)
//   o_bus_data_ready out  access complete
//   o_busy           out  access in progress (WAIT or DONE)
//
// state | meaning
// IDLE  | waiting for a strobe rising edge that hits the window
// WAIT  | access captured, counting down wait cycles
// DONE  | access completed, ready asserted until strobe falls

module cpu_bus_responder #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                IDX_W       = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int                WAIT_STATES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_busy
);

    localparam int NUM_REGS = 2 ** IDX_W;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("cpu_bus_responder: WAIT_STATES must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               strobe_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               hit;
    logic               start;
    logic               commit;
    logic               wr_en;
    logic [DATA_W-1:0]  rd_val;

    assign hit    = (i_bus_addr[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]);
    assign start  = i_bus_clk & ~strobe_q & hit & (state_q == ST_IDLE);
    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign o_busy = (state_q != ST_IDLE);

`ifdef BUS_RESP_ACCESS_CNT_EN
    logic [DATA_W-1:0] acc_cnt_q;

    // Top index is the counter: writes to it are acknowledged but dropped,
    // reads see the count before this access is added.
    always_comb begin
        wr_en  = commit & we_q & (idx_q != IDX_W'(NUM_REGS - 1));
        rd_val = regs_q[idx_q];
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            rd_val = acc_cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc_cnt_q <= '0;
        end else if (commit) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
        end
    end
`else
    always_comb begin
        wr_en  = commit & we_q;
        rd_val = regs_q[idx_q];
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DONE;
            ST_DONE: if (!i_bus_clk) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            strobe_q <= 1'b0;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= i_bus_clk;
            if (start) begin
                we_q    <= i_bus_we;
                idx_q   <= i_bus_addr[IDX_W-1:0];
                wdata_q <= i_bus_data;
                cnt_q   <= 4'(WAIT_STATES);
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    // Ready follows DONE by one clock and drops on the edge that sees the
    // strobe low; read data is loaded on entry to DONE and cleared on exit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b0;
        end else begin
            o_bus_data_ready <= (state_q == ST_DONE) && i_bus_clk;
            if (commit) begin
                o_bus_data <= we_q ? '0 : rd_val;
            end else if (state_q == ST_DONE && !i_bus_clk) begin
                o_bus_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strobe;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;

    logic [31:0] d0, d1;
    logic        r0, r1, b0, b1;
    logic [31:0] cur_data;
    logic        cur_rdy, cur_busy;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: per instance register image and access count
    logic [31:0] mem [2][8];
    logic [31:0] acc [2];

    always #5 clk = ~clk;

    cpu_bus_responder u_dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_bus_clk        (strobe & ~sel),
        .i_bus_we         (we),
        .i_bus_addr       (addr),
        .i_bus_data       (wdata),
        .o_bus_data       (d0),
        .o_bus_data_ready (r0),
        .o_busy           (b0)
    );

    cpu_bus_responder #(.WAIT_STATES(0)) u_dut_ws0 (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_bus_clk        (strobe & sel),
        .i_bus_we         (we),
        .i_bus_addr       (addr),
        .i_bus_data       (wdata),
        .o_bus_data       (d1),
        .o_bus_data_ready (r1),
        .o_busy           (b1)
    );

    assign cur_data = sel ? d1 : d0;
    assign cur_rdy  = sel ? r1 : r0;
    assign cur_busy = sel ? b1 : b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_cnt_idx(input logic [2:0] idx);
`ifdef BUS_RESP_ACCESS_CNT_EN
        return idx == 3'd7;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int u, input logic [2:0] idx);
        return is_cnt_idx(idx) ? acc[u] : mem[u][idx];
    endfunction

    task automatic model_commit(input int u, input logic w, input logic [2:0] idx, input logic [31:0] data);
        acc[u] = acc[u] + 32'd1;
        if (w && !is_cnt_idx(idx)) mem[u][idx] = data;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            acc[u] = 32'd0;
            for (int i = 0; i < 8; i++) mem[u][i] = 32'd0;
        end
    endtask

    // One full hit access on the selected instance, with latency and handshake checks.
    task automatic access(input logic w, input logic [2:0] idx, input logic [31:0] data, input int hold);
        int u;
        int lat;
        int exp_lat;
        logic [31:0] exp_rd;
        u       = sel ? 1 : 0;
        exp_lat = sel ? 2 : 4;
        exp_rd  = w ? 32'd0 : model_read(u, idx);
        @(negedge clk);
        we = w; addr = BASE | {29'd0, idx}; wdata = data; strobe = 1'b1;
        @(posedge clk); #1;
        check_val("wait_busy", {31'd0, cur_busy}, 32'd1);
        check_val("wait_data", cur_data, 32'd0);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (cur_rdy) break;
        end
        check_val("latency", lat, exp_lat);
        check_val("rdata", cur_data, exp_rd);
        @(negedge clk);
        addr = $urandom; wdata = $urandom; we = 1'($urandom);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val("hold_rdy", {31'd0, cur_rdy}, 32'd1);
            check_val("hold_data", cur_data, exp_rd);
        end
        @(negedge clk);
        strobe = 1'b0;
        @(posedge clk); #1;
        check_val("drop_rdy", {31'd0, cur_rdy}, 32'd0);
        check_val("drop_data", cur_data, 32'd0);
        check_val("drop_busy", {31'd0, cur_busy}, 32'd0);
        model_commit(u, w, idx, data);
    endtask

    task automatic miss_access(input int cycles);
        logic [31:0] a;
        logic seen_rdy, seen_busy, seen_data;
        a = $urandom;
        if (a[31:3] == BASE[31:3]) a[8] = ~a[8];
        @(negedge clk);
        addr = a; we = 1'($urandom); wdata = $urandom; strobe = 1'b1;
        seen_rdy = 0; seen_busy = 0; seen_data = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            seen_rdy  |= cur_rdy;
            seen_busy |= cur_busy;
            seen_data |= (cur_data != 32'd0);
        end
        check_val("miss_rdy", {31'd0, seen_rdy}, 32'd0);
        check_val("miss_busy", {31'd0, seen_busy}, 32'd0);
        check_val("miss_data", {31'd0, seen_data}, 32'd0);
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; strobe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [31:0] d;
        rst_n = 1'b0; strobe = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_rdy", {31'd0, r0}, 32'd0);
        check_val("rst_data", d0, 32'd0);
        check_val("rst_busy", {31'd0, b0}, 32'd0);

        // write then read back at FF03
        access(1'b1, 3'd3, 32'hCAFE_F00D, 1);
        access(1'b0, 3'd3, 32'd0, 2);

        // re-strobe during WAIT must not start a second access
        d = $urandom;
        @(negedge clk);
        we = 1'b1; addr = BASE | 32'd4; wdata = d; strobe = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (lat == 0) begin
                strobe = 1'b0; addr = BASE | 32'd5; wdata = ~d;
            end else if (lat == 1) begin
                strobe = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
            if (r0) break;
        end
        check_val("restrobe_lat", lat, 32'd4);
        @(negedge clk);
        strobe = 1'b0;
        @(posedge clk);
        model_commit(0, 1'b1, 3'd4, d);
        access(1'b0, 3'd5, 32'd0, 0);
        access(1'b0, 3'd4, 32'd0, 0);

        // window miss
        miss_access(50);

        // zero-wait instance
        sel = 1'b1;
        access(1'b1, 3'd0, 32'h1234_5678, 0);
        access(1'b0, 3'd0, 32'd0, 1);
        sel = 1'b0;

        // randomized mix on both instances
        for (int k = 0; k < 40; k++) begin
            sel = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                miss_access(8);
            end else begin
                access(1'($urandom), 3'($urandom), $urandom, int'($urandom_range(0, 3)));
            end
        end
        sel = 1'b0;

        // index 7: access counter or scratch register depending on build
        do_reset();
        access(1'b1, 3'd1, 32'h0000_0011, 0);
        access(1'b0, 3'd1, 32'd0, 0);
        access(1'b0, 3'd2, 32'd0, 0);
        access(1'b0, 3'd7, 32'd0, 0);
        access(1'b1, 3'd7, 32'h0000_0055, 0);
        access(1'b0, 3'd7, 32'd0, 0);
`ifdef BUS_RESP_ACCESS_CNT_EN
        check_val("cnt_model", acc[0], 32'd6);
`endif

        // reset during WAIT of a write discards it
        sel = 1'b0;
        @(negedge clk);
        we = 1'b1; addr = BASE | 32'd2; wdata = 32'hDEAD_BEEF; strobe = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0; strobe = 1'b0;
        #1;
        check_val("abort_rdy", {31'd0, r0}, 32'd0);
        check_val("abort_data", d0, 32'd0);
        check_val("abort_busy", {31'd0, b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        access(1'b0, 3'd2, 32'd0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
